buzzer_arbiter: RTL

- Shares the single board buzzer among three sound requesters with fixed priority:
  - 0 = alarm (highest)
  - 1 = key-click beep
  - 2 = melody sequencer (lowest)
- Each grant plays one note (period, duration), then a short silent articulation gap.
- A higher-priority request preempts a lower one. Sits between sound sources and the buzzer pin.

---
 rtl/buzzer_pkg.sv | 39 +++
 rtl/buzzer_tone.sv | 42 ++++
 rtl/buzzer_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer arbiter: FSM states, requester
// indices, default widths and note periods at 50 MHz.
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int NUM_REQ   = 3;
    localparam int REQ_ALARM = 0;
    localparam int REQ_KEY   = 1;
    localparam int REQ_MEL   = 2;

    localparam int DEF_PER_W    = 17;
    localparam int DEF_DUR_W    = 12;
    localparam int DEF_TICK_DIV = 50000;
    localparam int DEF_GAP_MS   = 8;

    localparam int M1 = 95600;
    localparam int M2 = 85150;
    localparam int M3 = 75850;
    localparam int M5 = 63750;
    localparam int M6 = 56800;
    localparam int M7 = 50600;
    localparam int H1 = 47750;

    // Lowest index wins; returns 0 when nothing is requested.
    function automatic logic [1:0] pick_winner(input logic [2:0] r);
        logic [1:0] w;
        w = 2'd0;
        if (r[0])      w = 2'd0;
        else if (r[1]) w = 2'd1;
        else if (r[2]) w = 2'd2;
        return w;
    endfunction

endpackage

// File: rtl/buzzer_tone.sv
// Square-wave generator: free-running period counter with a half-period
// compare. Periods of 0 or 1 produce silence.
module buzzer_tone
    import buzzer_pkg::*;
#(
    parameter int PER_W = DEF_PER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [PER_W-1:0] per,
    output logic             wave
);

    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;

    always_comb begin
        cnt_d  = cnt_q;
        wave_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else begin
            wave_d = (per[PER_W-1:1] != '0) && (cnt_q < (per >> 1));
            if (cnt_q >= per - 1'b1) cnt_d = '0;
            else                     cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority arbiter sharing one buzzer among alarm, key-click and melody.
// Optional BUZZER_MUTE_EN adds a mute input that silences the pin only.
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int PER_W    = DEF_PER_W,
    parameter int DUR_W    = DEF_DUR_W,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int GAP_MS   = DEF_GAP_MS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             req,
    input  logic [3*PER_W-1:0]     per_i,
    input  logic [3*DUR_W-1:0]     dur_i,
`ifdef BUZZER_MUTE_EN
    input  logic                   mute,
`endif
    output logic [2:0]             ack,
    output logic [2:0]             done,
    output logic [2:0]             abrt,
    output logic [1:0]             owner,
    output logic                   busy,
    output logic                   buzzer
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_MS);

    logic [PER_W-1:0] per_arr [NUM_REQ];
    logic [DUR_W-1:0] dur_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign per_arr[gi] = per_i[gi*PER_W +: PER_W];
            assign dur_arr[gi] = dur_i[gi*DUR_W +: DUR_W];
        end
    endgenerate

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [1:0]       owner_q, owner_d;
    logic [2:0]       ack_q, ack_d, done_q, done_d, abrt_q, abrt_d;

    logic [1:0] win_idx;
    logic       win_any, tick, finish, accept, preempt, tone_clr, wave;

    // Completion outranks preemption; a waiting higher request is taken from GAP.
    always_comb begin : decide
        win_any = |req;
        win_idx = pick_winner(req);
        tick    = (pre_q == PRE_LAST);
        finish  = (state_q == PLAY) &&
                  ((rem_q == '0) || (tick && rem_q == DUR_W'(1)));
        preempt = (state_q == PLAY) && !finish && win_any && (win_idx < owner_q);
        accept  = win_any &&
                  ((state_q == IDLE) || (!finish && (win_idx < owner_q)));
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = PLAY;
            PLAY: if (finish) state_d = (rem_q == '0) ? IDLE : GAP;
            GAP: begin
                if (accept)
                    state_d = PLAY;
                else if (gap_q == '0 || (tick && gap_q == GAP_W'(1)))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : datapath
        pre_d   = (accept || finish || state_q == IDLE || tick) ? '0 : pre_q + 1'b1;
        rem_d   = rem_q;
        gap_d   = gap_q;
        per_d   = per_q;
        owner_d = owner_q;
        if (accept) begin
            rem_d   = dur_arr[win_idx];
            per_d   = per_arr[win_idx];
            owner_d = win_idx;
        end else if (state_q == PLAY && tick && !finish) begin
            rem_d = rem_q - 1'b1;
        end
        if (finish)
            gap_d = GAP_LOAD;
        else if (state_q == GAP && tick && gap_q != '0)
            gap_d = gap_q - 1'b1;
    end

    always_comb begin : outputs
        ack_d    = accept  ? (3'b001 << win_idx) : 3'b000;
        done_d   = finish  ? (3'b001 << owner_q) : 3'b000;
        abrt_d   = preempt ? (3'b001 << owner_q) : 3'b000;
        tone_clr = accept || (state_d != PLAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            per_q   <= '0;
            owner_q <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            abrt_q  <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            per_q   <= per_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
        end
    end

    buzzer_tone #(.PER_W(PER_W)) u_tone (
        .clk  (clk),
        .rst  (rst),
        .clr  (tone_clr),
        .per  (per_q),
        .wave (wave)
    );

    assign ack   = ack_q;
    assign done  = done_q;
    assign abrt  = abrt_q;
    assign owner = owner_q;
    assign busy  = (state_q != IDLE);
`ifdef BUZZER_MUTE_EN
    assign buzzer = wave & ~mute;
`else
    assign buzzer = wave;
`endif

endmodule
